// File: rtl/wb_arbiter_n.sv
// N-port Wishbone classic arbiter.
// Grants are registered and never preempted. Arbitration is either fixed priority
// or round-robin. An optional watchdog terminates a hung slave access with ERR.
module wb_arbiter_n #(
  parameter int    PORTS        = 4,
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 32,
  parameter int    SELECT_WIDTH = DATA_WIDTH / 8,
  parameter string ARB_TYPE     = "PRIORITY",
  parameter string LSB_PRIORITY = "HIGH",
  parameter int    TIMEOUT      = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PORTS*ADDR_WIDTH-1:0]     wbm_adr_i,
  input  logic [PORTS*DATA_WIDTH-1:0]     wbm_dat_i,
  output logic [DATA_WIDTH-1:0]           wbm_dat_o,
  input  logic [PORTS-1:0]                wbm_we_i,
  input  logic [PORTS*SELECT_WIDTH-1:0]   wbm_sel_i,
  input  logic [PORTS-1:0]                wbm_stb_i,
  input  logic [PORTS-1:0]                wbm_cyc_i,
  output logic [PORTS-1:0]                wbm_ack_o,
  output logic [PORTS-1:0]                wbm_err_o,
  output logic [PORTS-1:0]                wbm_rty_o,
  output logic [PORTS-1:0]                wbm_arb_sel,
  output logic [$clog2(PORTS)-1:0]        grant_enc,
  output logic                            grant_valid,
  output logic                            timeout_o,
  output logic [ADDR_WIDTH-1:0]           wbs_adr_o,
  output logic [DATA_WIDTH-1:0]           wbs_dat_o,
  output logic                            wbs_we_o,
  output logic [SELECT_WIDTH-1:0]         wbs_sel_o,
  output logic                            wbs_stb_o,
  output logic                            wbs_cyc_o,
  input  logic [DATA_WIDTH-1:0]           wbs_dat_i,
  input  logic                            wbs_ack_i,
  input  logic                            wbs_err_i,
  input  logic                            wbs_rty_i
);

  localparam int GW       = $clog2(PORTS);
  localparam bit IS_RR    = (ARB_TYPE == "ROUND_ROBIN");
  localparam bit LSB_HIGH = (LSB_PRIORITY != "LOW");
  // Pointer start value chosen so the first round-robin search begins at the
  // port that fixed priority would favour.
  localparam logic [GW-1:0] RR_INIT = LSB_HIGH ? GW'(PORTS - 1) : '0;

  logic          r_grant_valid;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] r_rr_last;
  logic [GW-1:0] w_next;
  logic          w_found;
  logic          w_load;
  logic          w_timeout;
  logic          w_resp;

  // Port examined at search position i; the order depends on mode and tie direction.
  function automatic logic [GW-1:0] order_idx(input int i, input logic [GW-1:0] last);
    int k;
    if (!IS_RR)
      k = LSB_HIGH ? i : (PORTS - 1 - i);
    else if (LSB_HIGH)
      k = (int'(last) + 1 + i) % PORTS;
    else
      k = (int'(last) + 2 * PORTS - 1 - i) % PORTS;
    return GW'(k);
  endfunction

  // Pick the first requester in search order.
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (!w_found && wbm_cyc_i[order_idx(i, r_rr_last)]) begin
        w_found = 1'b1;
        w_next  = order_idx(i, r_rr_last);
      end
    end
  end

  // Re-arbitrate only when idle or when the holder has released its cycle.
  assign w_load = !r_grant_valid || !wbm_cyc_i[r_grant];

  // Grant register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant_valid <= 1'b0;
      r_grant       <= '0;
      r_rr_last     <= RR_INIT;
    end else if (w_load) begin
      r_grant_valid <= w_found;
      if (w_found) begin
        r_grant   <= w_next;
        r_rr_last <= w_next;
      end
    end
  end

  // Slave-side mux; the strobe is withheld in the cycle the watchdog terminates the access.
  always_comb begin
    wbs_cyc_o = r_grant_valid & wbm_cyc_i[r_grant];
    wbs_stb_o = wbs_cyc_o & wbm_stb_i[r_grant] & ~w_timeout;
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_we_o  = 1'b0;
    wbs_sel_o = '0;
    if (r_grant_valid) begin
      wbs_adr_o = wbm_adr_i[int'(r_grant)*ADDR_WIDTH +: ADDR_WIDTH];
      wbs_dat_o = wbm_dat_i[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
      wbs_we_o  = wbm_we_i[r_grant];
      wbs_sel_o = wbm_sel_i[int'(r_grant)*SELECT_WIDTH +: SELECT_WIDTH];
    end
  end

  // Responses are routed only to the granted port.
  always_comb begin
    wbm_ack_o   = '0;
    wbm_err_o   = '0;
    wbm_rty_o   = '0;
    wbm_arb_sel = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (r_grant_valid && (r_grant == GW'(k))) begin
        wbm_ack_o[k]   = wbs_ack_i;
        wbm_err_o[k]   = wbs_err_i | w_timeout;
        wbm_rty_o[k]   = wbs_rty_i;
        wbm_arb_sel[k] = 1'b1;
      end
    end
  end

  assign w_resp      = wbs_ack_i | wbs_err_i | wbs_rty_i;
  assign wbm_dat_o   = wbs_dat_i;
  assign grant_enc   = r_grant;
  assign grant_valid = r_grant_valid;
  assign timeout_o   = w_timeout;

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] r_wd_cnt;
      logic          r_timeout;

      // Count unanswered strobe cycles; fire a single-cycle termination on the last one.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_wd_cnt  <= '0;
          r_timeout <= 1'b0;
        end else begin
          r_timeout <= 1'b0;
          if (w_load || !(wbs_cyc_o && wbs_stb_o) || w_resp) begin
            r_wd_cnt <= '0;
          end else if (r_wd_cnt == CW'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_wd_cnt  <= '0;
          end else begin
            r_wd_cnt <= r_wd_cnt + CW'(1);
          end
        end
      end

      assign w_timeout = r_timeout;
    end else begin : g_no_wd
      assign w_timeout = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench for wb_arbiter_n: one priority instance with an 8-cycle watchdog
// and one round-robin instance, both fed from the same master/slave stimulus.
module tb_wb_arbiter_n;
  localparam int P  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [P*AW-1:0] adr;
  logic [P*DW-1:0] mdat;
  logic [P-1:0]    we;
  logic [P*SW-1:0] sel;
  logic [P-1:0]    stb;
  logic [P-1:0]    cyc;
  logic [DW-1:0]   sdat;
  logic            ack, err, rty;

  logic [DW-1:0] p_dat_o, q_dat_o;
  logic [P-1:0]  p_ack, p_err, p_rty, p_sel, q_ack, q_err, q_rty, q_sel;
  logic [1:0]    p_enc, q_enc;
  logic          p_gv, p_tmo, q_gv, q_tmo;
  logic [AW-1:0] p_sadr, q_sadr;
  logic [DW-1:0] p_sdat, q_sdat;
  logic          p_swe, p_sstb, p_scyc, q_swe, q_sstb, q_scyc;
  logic [SW-1:0] p_ssel, q_ssel;

  wb_arbiter_n #(.PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARB_TYPE("PRIORITY"),
                 .LSB_PRIORITY("HIGH"), .TIMEOUT(8)) u_pri (
    .clk(clk), .rst(rst), .wbm_adr_i(adr), .wbm_dat_i(mdat), .wbm_dat_o(p_dat_o),
    .wbm_we_i(we), .wbm_sel_i(sel), .wbm_stb_i(stb), .wbm_cyc_i(cyc),
    .wbm_ack_o(p_ack), .wbm_err_o(p_err), .wbm_rty_o(p_rty), .wbm_arb_sel(p_sel),
    .grant_enc(p_enc), .grant_valid(p_gv), .timeout_o(p_tmo),
    .wbs_adr_o(p_sadr), .wbs_dat_o(p_sdat), .wbs_we_o(p_swe), .wbs_sel_o(p_ssel),
    .wbs_stb_o(p_sstb), .wbs_cyc_o(p_scyc), .wbs_dat_i(sdat), .wbs_ack_i(ack),
    .wbs_err_i(err), .wbs_rty_i(rty));

  wb_arbiter_n #(.PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ARB_TYPE("ROUND_ROBIN"),
                 .LSB_PRIORITY("HIGH"), .TIMEOUT(0)) u_rr (
    .clk(clk), .rst(rst), .wbm_adr_i(adr), .wbm_dat_i(mdat), .wbm_dat_o(q_dat_o),
    .wbm_we_i(we), .wbm_sel_i(sel), .wbm_stb_i(stb), .wbm_cyc_i(cyc),
    .wbm_ack_o(q_ack), .wbm_err_o(q_err), .wbm_rty_o(q_rty), .wbm_arb_sel(q_sel),
    .grant_enc(q_enc), .grant_valid(q_gv), .timeout_o(q_tmo),
    .wbs_adr_o(q_sadr), .wbs_dat_o(q_sdat), .wbs_we_o(q_swe), .wbs_sel_o(q_ssel),
    .wbs_stb_o(q_sstb), .wbs_cyc_o(q_scyc), .wbs_dat_i(sdat), .wbs_ack_i(ack),
    .wbs_err_i(err), .wbs_rty_i(rty));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are checked on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    cyc = '0; stb = '0; ack = 1'b0; err = 1'b0; rty = 1'b0;
    sdat = 32'h5555_AAAA;
    we   = 4'b1010;
    sel  = 16'h8421;
    for (int k = 0; k < P; k++) begin
      adr[k*AW +: AW]  = 32'hA000_0000 + 32'(k);
      mdat[k*DW +: DW] = 32'hD000_0000 + 32'(k);
    end

    // Reset state
    step(); step(); mid();
    chk("rst_gv", p_gv, 0);
    chk("rst_enc", p_enc, 0);
    chk("rst_tmo", p_tmo, 0);
    chk("rst_scyc", p_scyc, 0);
    chk("rst_sadr", p_sadr, 0);
    chk("rst_arbsel", p_sel, 0);
    chk("rst_rr_gv", q_gv, 0);
    step(); rst = 1'b0; mid();
    chk("post_rst_gv", p_gv, 0);

    // Two simultaneous requests: lowest index wins, the other follows without a gap
    step(); cyc = 4'b0110; stb = 4'b0110; mid();
    chk("t1_latency_scyc", p_scyc, 0);
    step(); ack = 1'b1; mid();
    chk("t1_enc", p_enc, 1);
    chk("t1_gv", p_gv, 1);
    chk("t1_scyc", p_scyc, 1);
    chk("t1_sadr", p_sadr, 32'hA000_0001);
    chk("t1_sdat", p_sdat, 32'hD000_0001);
    chk("t1_ssel", p_ssel, 4'h2);
    chk("t1_swe", p_swe, 1);
    chk("t1_arbsel", p_sel, 4'b0010);
    chk("t1_ack", p_ack, 4'b0010);
    chk("t1_mdat_o", p_dat_o, 32'h5555_AAAA);
    step(); cyc = 4'b0100; ack = 1'b0; mid();
    chk("t1_release_enc", p_enc, 1);
    chk("t1_release_scyc", p_scyc, 0);
    step(); mid();
    chk("t1_enc2", p_enc, 2);
    chk("t1_scyc2", p_scyc, 1);
    chk("t1_sadr2", p_sadr, 32'hA000_0002);
    chk("t1_ack_none", p_ack, 0);
    step(); cyc = '0; stb = '0; mid();
    step(); mid();
    chk("t1_idle_gv", p_gv, 0);
    chk("t1_idle_sadr", p_sadr, 0);

    // No preemption of a held grant
    step(); cyc = 4'b1000; stb = 4'b1000; ack = 1'b1; mid();
    step(); mid();
    chk("t3_enc3", p_enc, 3);
    step(); cyc = 4'b1001; stb = 4'b1001; mid();
    chk("t3_hold_a", p_enc, 3);
    step(); mid();
    chk("t3_hold_b", p_enc, 3);
    chk("t3_ack3", p_ack, 4'b1000);
    step(); cyc = 4'b0001; mid();
    chk("t3_release_enc", p_enc, 3);
    chk("t3_release_scyc", p_scyc, 0);
    step(); mid();
    chk("t3_enc0", p_enc, 0);
    chk("t3_ack0", p_ack, 4'b0001);
    chk("t3_sadr0", p_sadr, 32'hA000_0000);
    step(); cyc = '0; stb = '0; ack = 1'b0; mid();
    step(); mid();
    chk("t3_idle_gv", p_gv, 0);

    // Watchdog fires 8 cycles after the first unanswered strobe
    step(); cyc = 4'b0100; stb = 4'b0100; mid();
    step(); mid();
    chk("t4_enc", p_enc, 2);
    chk("t4_sstb", p_sstb, 1);
    chk("t4_tmo_a1", p_tmo, 0);
    for (int i = 0; i < 7; i++) begin
      step(); mid();
      chk("t4_tmo_quiet", p_tmo, 0);
    end
    step(); mid();
    chk("t4_tmo_fire", p_tmo, 1);
    chk("t4_err", p_err, 4'b0100);
    chk("t4_sstb_forced", p_sstb, 0);
    chk("t4_scyc_held", p_scyc, 1);
    chk("t4_gv_held", p_gv, 1);
    step(); mid();
    chk("t4_tmo_clear", p_tmo, 0);
    chk("t4_err_clear", p_err, 0);
    chk("t4_sstb_back", p_sstb, 1);

    // Ack on the 8th strobe cycle prevents the timeout; the next access times out afresh
    for (int i = 0; i < 6; i++) begin
      step(); mid();
      chk("t5_tmo_quiet_a", p_tmo, 0);
    end
    step(); ack = 1'b1; mid();
    chk("t5_ack", p_ack, 4'b0100);
    chk("t5_tmo_ack_cycle", p_tmo, 0);
    step(); ack = 1'b0; mid();
    chk("t5_no_tmo", p_tmo, 0);
    for (int i = 0; i < 7; i++) begin
      step(); mid();
      chk("t5_tmo_quiet_b", p_tmo, 0);
    end
    step(); ack = 1'b1; mid();
    chk("t5_tmo_fresh", p_tmo, 1);
    chk("t5_err_fresh", p_err, 4'b0100);
    chk("t5_ack_passthru", p_ack, 4'b0100);
    step(); ack = 1'b0; cyc = '0; stb = '0; mid();
    chk("t5_tmo_end", p_tmo, 0);
    step(); mid();

    // Reset in the middle of a granted transfer
    step(); cyc = 4'b0010; stb = 4'b0010; mid();
    step(); mid();
    chk("t6_enc", p_enc, 1);
    chk("t6_scyc", p_scyc, 1);
    chk("t6_sstb", p_sstb, 1);
    step(); rst = 1'b1; mid();
    chk("t6_sync_gv", p_gv, 1);
    step(); ack = 1'b1; mid();
    chk("t6_gv", p_gv, 0);
    chk("t6_scyc_drop", p_scyc, 0);
    chk("t6_ack_blocked", p_ack, 0);
    step(); rst = 1'b0; cyc = '0; stb = '0; mid();
    chk("t6_ack_blocked2", p_ack, 0);
    chk("t6_gv2", p_gv, 0);
    step(); ack = 1'b0; mid();

    // Round robin: grant sequence 0,1,2,3,0 with grant held across every hand-over
    step(); cyc = 4'b1111; stb = 4'b1111; mid();
    chk("t2_latency", q_gv, 0);
    step(); ack = 1'b1; mid();
    chk("t2_g0", q_enc, 0);
    chk("t2_ack0", q_ack, 4'b0001);
    step(); cyc = 4'b1110; ack = 1'b0; mid();
    chk("t2_gv_a", q_gv, 1);
    step(); cyc = 4'b1111; ack = 1'b1; mid();
    chk("t2_g1", q_enc, 1);
    chk("t2_gv_b", q_gv, 1);
    step(); cyc = 4'b1101; ack = 1'b0; mid();
    chk("t2_gv_c", q_gv, 1);
    step(); ack = 1'b1; mid();
    chk("t2_g2", q_enc, 2);
    chk("t2_gv_d", q_gv, 1);
    step(); cyc = 4'b1001; ack = 1'b0; mid();
    chk("t2_gv_e", q_gv, 1);
    step(); ack = 1'b1; mid();
    chk("t2_g3", q_enc, 3);
    chk("t2_sadr3", q_sadr, 32'hA000_0003);
    chk("t2_gv_f", q_gv, 1);
    step(); cyc = 4'b0001; ack = 1'b0; mid();
    chk("t2_gv_g", q_gv, 1);
    step(); mid();
    chk("t2_g0_wrap", q_enc, 0);
    chk("t2_gv_h", q_gv, 1);
    chk("t2_scyc", q_scyc, 1);
    step(); cyc = '0; stb = '0; mid();
    step(); mid();
    chk("t2_idle", q_gv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
